// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the 3-bit cyclic code path. The generator stage and
// seq_checker both use the code constants, so the two cannot drift apart.
//   state_e     : checker FSM states (HUNT, ACQ, LOCKED, LOSS)
//   CODE_*      : the four legal codes, in cycle order 000->010->011->101
//   next_code() : successor of a code; 000 for an illegal code
//   is_valid()  : 1 when the code is one of the four legal codes
// ---------------------------------------------------------------------------
package seq_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2,
    LOSS   = 2'd3
  } state_e;

  localparam logic [2:0] CODE_0 = 3'b000;
  localparam logic [2:0] CODE_1 = 3'b010;
  localparam logic [2:0] CODE_2 = 3'b011;
  localparam logic [2:0] CODE_3 = 3'b101;

  function automatic logic [2:0] next_code(input logic [2:0] c);
    logic [2:0] n;
    case (c)
      CODE_0:  n = CODE_1;
      CODE_1:  n = CODE_2;
      CODE_2:  n = CODE_3;
      CODE_3:  n = CODE_0;
      default: n = CODE_0;
    endcase
    return n;
  endfunction

  function automatic logic is_valid(input logic [2:0] c);
    return (c == CODE_0) || (c == CODE_1) || (c == CODE_2) || (c == CODE_3);
  endfunction

endpackage

// File: rtl/seq_checker.sv
// ---------------------------------------------------------------------------
// seq_checker
// Locks onto the cyclic code stream from the generator stage, then flywheels a
// predicted code, counting mismatches and flagging frame starts (code 000).
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   en       in   sample strobe; din is consumed only when en=1
//   din      in   [2:0] code from the generator stage
//   locked   out  high in LOCKED and LOSS
//   err      out  one-cycle pulse on a mismatch while locked
//   err_cnt  out  [ERR_W-1:0] saturating mismatch count since reset
//   frame    out  one-cycle pulse on a matched 000 while locked
//   expected out  [2:0] predicted next code; 000 when not locked
// All outputs are registered: one cycle of latency from the sampling edge.
// ---------------------------------------------------------------------------
module seq_checker
  import seq_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       din,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic             frame,
  output logic [2:0]       expected
);

  localparam logic [3:0] LOCK_CNT_C = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_CNT_C = 4'(LOSS_CNT);

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  state_e           state_q, state_d;
  logic [2:0]       prev_q, prev_d;
  logic [3:0]       run_q, run_d;
  logic [3:0]       miss_q, miss_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic             frame_q, frame_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [2:0]       expected_q, expected_d;

  logic             match;
  logic             in_lock;

  assign match   = (din == next_code(prev_q));
  assign in_lock = (state_q == LOCKED) || (state_q == LOSS);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HUNT;
      prev_q     <= CODE_0;
      run_q      <= '0;
      miss_q     <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      frame_q    <= 1'b0;
      err_cnt_q  <= '0;
      expected_q <= CODE_0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      run_q      <= run_d;
      miss_q     <= miss_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      frame_q    <= frame_d;
      err_cnt_q  <= err_cnt_d;
      expected_q <= expected_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    run_d   = run_q;
    miss_d  = miss_q;
    if (en) begin
      case (state_q)
        HUNT: begin
          if (is_valid(din)) begin
            state_d = ACQ;
            prev_d  = din;
            run_d   = '0;
          end
        end
        ACQ: begin
          if (match) begin
            run_d  = run_q + 4'd1;
            prev_d = din;
            if (run_q + 4'd1 == LOCK_CNT_C) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else if (is_valid(din)) begin
            // A legal but out-of-order code restarts the run from this code.
            run_d  = '0;
            prev_d = din;
          end else begin
            state_d = HUNT;
          end
        end
        LOCKED: begin
          if (match) begin
            prev_d = din;
          end else begin
            // Flywheel: advance the prediction as if the right code arrived.
            prev_d  = next_code(prev_q);
            miss_d  = 4'd1;
            state_d = (LOSS_CNT_C == 4'd1) ? HUNT : LOSS;
          end
        end
        LOSS: begin
          if (match) begin
            state_d = LOCKED;
            miss_d  = '0;
            prev_d  = din;
          end else begin
            prev_d = next_code(prev_q);
            miss_d = miss_q + 4'd1;
            if (miss_q + 4'd1 == LOSS_CNT_C) state_d = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Output logic: outputs are computed from the next state so that they
  // appear on the edge that consumed the sample.
  always_comb begin
    err_d      = en && in_lock && !match;
    frame_d    = en && in_lock && match && (din == CODE_0);
    err_cnt_d  = err_d ? sat_inc(err_cnt_q) : err_cnt_q;
    locked_d   = (state_d == LOCKED) || (state_d == LOSS);
    expected_d = locked_d ? next_code(prev_d) : CODE_0;
  end

  assign locked   = locked_q;
  assign err      = err_q;
  assign frame    = frame_q;
  assign err_cnt  = err_cnt_q;
  assign expected = expected_q;

endmodule

// File: tb/tb_seq_checker.sv
// ---------------------------------------------------------------------------
// tb_seq_checker
// Directed bench for seq_checker. A default instance (LOCK_CNT=4, LOSS_CNT=3,
// ERR_W=8) and a narrow-counter instance (ERR_W=2) share the same inputs.
// A vector table covers acquisition, glitch, en hold and loss of lock; the
// hand-written sequences cover en gaps, counter saturation and reset mid-lock.
// ---------------------------------------------------------------------------
module tb_seq_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] din;

  logic       locked_a, err_a, frame_a;
  logic [7:0] err_cnt_a;
  logic [2:0] expected_a;

  logic       locked_b, err_b, frame_b;
  logic [1:0] err_cnt_b;
  logic [2:0] expected_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(8)) dut_a (
    .clk(clk), .rst(rst), .en(en), .din(din),
    .locked(locked_a), .err(err_a), .err_cnt(err_cnt_a),
    .frame(frame_a), .expected(expected_a)
  );

  seq_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(2)) dut_b (
    .clk(clk), .rst(rst), .en(en), .din(din),
    .locked(locked_b), .err(err_b), .err_cnt(err_cnt_b),
    .frame(frame_b), .expected(expected_b)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] din;
    logic       locked;
    logic       err;
    logic       frame;
    logic [2:0] expected;
    logic [7:0] err_cnt;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic e, input logic [2:0] d);
    @(negedge clk);
    rst = r;
    en  = e;
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic acquire();
    step(1'b0, 1'b1, 3'b000);
    step(1'b0, 1'b1, 3'b010);
    step(1'b0, 1'b1, 3'b011);
    step(1'b0, 1'b1, 3'b101);
    step(1'b0, 1'b1, 3'b000);
  endtask

  // One glitch in place of 010 while locked on 000, then relock.
  task automatic glitch_cycle();
    step(1'b0, 1'b1, 3'b111);
    chk("glitch_err", {7'd0, err_a}, 8'd1);
    chk("glitch_locked", {7'd0, locked_a}, 8'd1);
    step(1'b0, 1'b1, 3'b011);
    step(1'b0, 1'b1, 3'b101);
    step(1'b0, 1'b1, 3'b000);
    chk("relock_frame", {7'd0, frame_a}, 8'd1);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    din = 3'b000;

    //            rst  en   din     lck  err  frm  exp     cnt
    vq.push_back('{1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 8'd0});
    vq.push_back('{1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 8'd0});
    vq.push_back('{1'b0, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 3'b000, 8'd0});
    vq.push_back('{1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 3'b000, 8'd0});
    vq.push_back('{1'b0, 1'b1, 3'b101, 1'b0, 1'b0, 1'b0, 3'b000, 8'd0});
    vq.push_back('{1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 3'b010, 8'd0});
    vq.push_back('{1'b0, 1'b1, 3'b010, 1'b1, 1'b0, 1'b0, 3'b011, 8'd0});
    vq.push_back('{1'b0, 1'b1, 3'b011, 1'b1, 1'b0, 1'b0, 3'b101, 8'd0});
    vq.push_back('{1'b0, 1'b1, 3'b101, 1'b1, 1'b0, 1'b0, 3'b000, 8'd0});
    vq.push_back('{1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 1'b1, 3'b010, 8'd0});
    vq.push_back('{1'b0, 1'b1, 3'b010, 1'b1, 1'b0, 1'b0, 3'b011, 8'd0});
    // glitch: 111 in place of 011
    vq.push_back('{1'b0, 1'b1, 3'b111, 1'b1, 1'b1, 1'b0, 3'b101, 8'd1});
    vq.push_back('{1'b0, 1'b1, 3'b101, 1'b1, 1'b0, 1'b0, 3'b000, 8'd1});
    vq.push_back('{1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 1'b1, 3'b010, 8'd1});
    // en=0 holds everything, no pulses even with an illegal din
    vq.push_back('{1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 3'b010, 8'd1});
    vq.push_back('{1'b0, 1'b1, 3'b010, 1'b1, 1'b0, 1'b0, 3'b011, 8'd1});
    // three consecutive mismatches drop lock
    vq.push_back('{1'b0, 1'b1, 3'b000, 1'b1, 1'b1, 1'b0, 3'b101, 8'd2});
    vq.push_back('{1'b0, 1'b1, 3'b000, 1'b1, 1'b1, 1'b0, 3'b000, 8'd3});
    vq.push_back('{1'b0, 1'b1, 3'b111, 1'b0, 1'b1, 1'b0, 3'b000, 8'd4});
    // back in HUNT: a legal code moves to ACQ, nothing counted
    vq.push_back('{1'b0, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 3'b000, 8'd4});
    vq.push_back('{1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 8'd4});

    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].en, vq[i].din);
      chk($sformatf("v%0d_locked", i), {7'd0, locked_a}, {7'd0, vq[i].locked});
      chk($sformatf("v%0d_err", i), {7'd0, err_a}, {7'd0, vq[i].err});
      chk($sformatf("v%0d_frame", i), {7'd0, frame_a}, {7'd0, vq[i].frame});
      chk($sformatf("v%0d_expected", i), {5'd0, expected_a}, {5'd0, vq[i].expected});
      chk($sformatf("v%0d_err_cnt", i), err_cnt_a, vq[i].err_cnt);
    end

    // en toggling 1,0,1,0 on a clean stream: lock on the 5th enabled sample.
    begin
      logic [2:0] codes [5];
      codes[0] = 3'b000; codes[1] = 3'b010; codes[2] = 3'b011;
      codes[3] = 3'b101; codes[4] = 3'b000;
      step(1'b1, 1'b0, 3'b000);
      for (int i = 0; i < 5; i++) begin
        step(1'b0, 1'b1, codes[i]);
        chk($sformatf("gap%0d_locked", i), {7'd0, locked_a}, (i == 4) ? 8'd1 : 8'd0);
        step(1'b0, 1'b0, 3'b110);
        chk($sformatf("gap%0d_off_err", i), {7'd0, err_a}, 8'd0);
        chk($sformatf("gap%0d_off_frame", i), {7'd0, frame_a}, 8'd0);
        chk($sformatf("gap%0d_off_locked", i), {7'd0, locked_a}, (i == 4) ? 8'd1 : 8'd0);
      end
      chk("gap_expected", {5'd0, expected_a}, 8'h02);
      chk("gap_err_cnt", err_cnt_a, 8'd0);
    end

    // Saturation of the 2-bit counter over five glitches.
    step(1'b1, 1'b0, 3'b000);
    acquire();
    chk("sat_locked", {7'd0, locked_b}, 8'd1);
    for (int i = 0; i < 5; i++) begin
      glitch_cycle();
      chk($sformatf("sat%0d_cnt_w8", i), err_cnt_a, 8'(i + 1));
      chk($sformatf("sat%0d_cnt_w2", i), {6'd0, err_cnt_b}, (i + 1 > 3) ? 8'd3 : 8'(i + 1));
    end

    // Reset while locked with err_cnt=2; rst wins over en.
    step(1'b1, 1'b0, 3'b000);
    acquire();
    glitch_cycle();
    glitch_cycle();
    chk("pre_rst_cnt", err_cnt_a, 8'd2);
    step(1'b1, 1'b1, 3'b010);
    chk("rst_locked", {7'd0, locked_a}, 8'd0);
    chk("rst_err_cnt", err_cnt_a, 8'd0);
    chk("rst_expected", {5'd0, expected_a}, 8'd0);
    chk("rst_err", {7'd0, err_a}, 8'd0);
    step(1'b0, 1'b1, 3'b000);
    step(1'b0, 1'b1, 3'b010);
    step(1'b0, 1'b1, 3'b011);
    step(1'b0, 1'b1, 3'b101);
    chk("reacq_not_yet", {7'd0, locked_a}, 8'd0);
    step(1'b0, 1'b1, 3'b000);
    chk("reacq_locked", {7'd0, locked_a}, 8'd1);
    chk("reacq_expected", {5'd0, expected_a}, 8'h02);
    chk("reacq_err_cnt", err_cnt_a, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_checker.md
# seq_checker

Downstream consumer of the 3-bit sequence generator stage. Samples the generator's output stream, acquires lock onto the fixed cyclic code sequence 000 → 010 → 011 → 101 → 000, then flywheels a predicted value. Counts mismatches and emits a frame pulse at each 000 while locked. Its outputs feed the status/debug logic of the sequence path.

## Interface
- LOCK_CNT, 4, consecutive correct transitions needed to acquire lock (legal 1..15)
- LOSS_CNT, 3, consecutive mismatches that drop lock (legal 1..15)
- ERR_W, 8, width of the saturating error counter
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  sample strobe; din is consumed only on edges where en=1
- din  in  3  code from the generator stage
- locked  out  1  high in LOCKED and LOSS states
- err  out  1  one-cycle pulse: sampled din mismatched the prediction while locked
- err_cnt  out  ERR_W  total mismatches since reset, saturating at all-ones
- frame  out  1  one-cycle pulse: din=000 matched the prediction while locked
- expected  out  3  predicted next code; 000 when not locked

## Operation
- Valid codes: 000, 010, 011, 101. Invalid codes: 001, 100, 110, 111. next(c) follows the cycle above.
- Internal registers: state, prev[2:0], run[3:0], miss[3:0].
- HUNT: valid din → ACQ, prev=din, run=0. Invalid din → stay.
- ACQ:
  - din==next(prev) → run+1, prev=din; if run+1==LOCK_CNT → LOCKED.
  - Other valid din → stay in ACQ, run=0, prev=din.
  - Invalid din → HUNT.
- LOCKED:
  - din==next(prev) → stay, prev=din.
  - Mismatch → err pulse, err_cnt+1, miss=1, prev=next(prev) (flywheel). Go to LOSS, or to HUNT if LOSS_CNT==1.
- LOSS:
  - Match → LOCKED, miss=0, prev=din.
  - Mismatch → err pulse, err_cnt+1, prev=next(prev), miss+1; if miss+1==LOSS_CNT → HUNT.
- frame: asserted on a match in LOCKED or LOSS when din==000.
- No mismatch is counted in HUNT or ACQ.
- expected = next(prev) in LOCKED/LOSS, else 000.
- err_cnt holds at 2^ERR_W−1 once reached. It is cleared only by rst.

## Timing
- All outputs registered. A sample taken at edge k is reflected in outputs after edge k, i.e. 1-cycle latency.
- Reset values: state=HUNT, locked=0, err=0, err_cnt=0, frame=0, expected=000. Internal: prev=000, run=0, miss=0.
- rst wins over en. Reset mid-lock returns to HUNT on that edge, and err_cnt clears.
- en=0: all state, counters and expected hold; err and frame are 0 that cycle.
- From a clean stream after generator reset (000 during reset, then 010, 011, 101, 000, …), locked rises after edge 1+LOCK_CNT counted from the first en=1 sample.
- err and frame are never asserted together. On a clean locked stream, frame is high one cycle in every four enabled samples.

## Structure
- Shared package seq_pkg holds:
  - the state enum (HUNT, ACQ, LOCKED, LOSS)
  - the four code constants
  - function next_code(logic [2:0]) returning the successor (000 for invalid input)
- The generator stage reuses the same code constants.
- Single module, no sub-module; the predictor is the package function.

## Test plan
- Clean acquisition, LOCK_CNT=4, en=1: din 000, 010, 011, 101, 000 → locked=1 after 5th edge, expected=010, err_cnt=0. Subsequent 000 samples give frame=1.
- Single glitch while locked (011 replaced by 111) → err pulse for one cycle, err_cnt=1, locked stays 1. Next 101 matches and the FSM returns to LOCKED.
- Three consecutive mismatches, LOSS_CNT=3 → err pulses on 3 cycles, err_cnt=3, locked=0 after the 3rd edge, expected=000.
- en toggling 1,0,1,0 on a clean stream → lock reached after 4 enabled transitions regardless of gaps. No err; err and frame are 0 on en=0 cycles.
- ERR_W=2, 5 mismatches while locked (relock between them) → err_cnt saturates at 3.
- rst asserted while locked with err_cnt=2 → next edge: locked=0, err_cnt=0, expected=000, state HUNT. Reacquisition follows the first scenario.
